camera_init_seq: RTL
====================

CAMERA_INIT_SEQ -- requirements
Module: camera_init_seq

Interface
REQ-001 Parameter RST_LOW_CYC, default 1000: cycles o_camera_gpio is held low after a start.
REQ-002 Parameter PWR_WAIT_CYC, default 20000: cycles to wait after o_camera_gpio rises, before the first table fetch.
REQ-003 Parameter DELAY_UNIT, default 100: cycles per count of a table delay entry.
REQ-004 Parameter MAX_RETRY, default 3: maximum IIC attempts per table entry.
REQ-005 Parameter TBL_AW, default 8: table address width.
REQ-006 i_clk  in  1  single clock; all logic rising-edge.
REQ-007 i_rst  in  1  reset, asynchronous, active-low.
REQ-008 i_start  in  1  one-cycle pulse; begins the power-up and configuration sequence.
REQ-009 o_tbl_addr  out  TBL_AW  configuration table read address.
REQ-010 i_tbl_data  in  24  table entry {reg_addr[15:0], value[7:0]}; synchronous ROM, valid 1 cycle after o_tbl_addr.
REQ-011 o_iic_req  out  1  write request to the IIC master.
REQ-012 o_iic_addr  out  16  camera register address.
REQ-013 o_iic_data  out  8  camera register value.
REQ-014 i_iic_done  in  1  one-cycle pulse; IIC transaction finished.
REQ-015 i_iic_err  in  1  NACK flag; valid only when i_iic_done=1.
REQ-016 o_camera_gpio  out  1  camera power/enable pin.
REQ-017 o_busy  out  1  sequence in progress.
REQ-018 o_done  out  1  level; table completed successfully.
REQ-019 o_error  out  1  level; retries exhausted.
REQ-020 o_err_index  out  TBL_AW  table address of the failing entry.

Function
REQ-021 FSM states: IDLE, PWR_LOW, PWR_WAIT, FETCH, DECODE, WRITE, WAIT_ACK, DELAY, DONE, ERROR.
REQ-022 IDLE/DONE/ERROR + i_start -> PWR_LOW: o_tbl_addr=0, retry count=0, o_done=0, o_error=0, o_camera_gpio=0.
REQ-023 i_start in any other state is ignored.
REQ-024 PWR_LOW lasts exactly RST_LOW_CYC cycles, then o_camera_gpio=1 -> PWR_WAIT.
REQ-025 PWR_WAIT lasts exactly PWR_WAIT_CYC cycles -> FETCH.
REQ-026 FETCH: o_tbl_addr is stable -> DECODE next cycle; DECODE samples i_tbl_data.
REQ-027 DECODE, reg_addr=16'hFFFF (end marker) -> DONE.
REQ-028 DECODE, reg_addr=16'hFFFE (delay) -> DELAY for value*DELAY_UNIT cycles; value=0 -> 1 cycle in DELAY; then advance.
REQ-029 DECODE, any other reg_addr -> latch reg_addr and value into o_iic_addr/o_iic_data -> WRITE.
REQ-030 WRITE asserts o_iic_req -> WAIT_ACK; o_iic_req stays 1 with stable addr/data until i_iic_done, and drops in the cycle after the done pulse.
REQ-031 WAIT_ACK, i_iic_done and !i_iic_err -> advance; retry count=0.
REQ-032 WAIT_ACK, i_iic_done and i_iic_err -> retry count+1; if new count < MAX_RETRY -> WRITE (same entry); otherwise -> ERROR, o_err_index=o_tbl_addr.
REQ-033 Advance: o_tbl_addr+1 -> FETCH; if o_tbl_addr = 2^TBL_AW-1, -> DONE without wrapping.
REQ-034 i_iic_done outside WAIT_ACK is ignored.
REQ-035 o_busy=1 in every state except IDLE, DONE and ERROR.
REQ-036 o_done=1 only in DONE; o_error=1 only in ERROR; both hold until the next i_start.
REQ-037 o_camera_gpio stays 1 in DONE and ERROR.
REQ-038 Delay and power counters are wide enough for the parameter values and never wrap early.

Reset
REQ-039 i_rst=0 asynchronously forces IDLE with all outputs 0, including mid-transaction; o_iic_req drops immediately.
REQ-040 After reset release, the block stays in IDLE until i_start.

Verification
REQ-041 Table {0x3008,0x82},{0xFFFF,--}, IIC done after 10 cycles, no err -> gpio low 1000 cycles, high after that; one req addr=0x3008 data=0x82; o_done=1; o_tbl_addr=1.
REQ-042 Entry {0xFFFE,0x05} with DELAY_UNIT=100 -> 500 cycles between the DECODE of that entry and the next FETCH; no IIC request for that entry.
REQ-043 Entry 2 NACKs twice then ACKs -> 3 requests with identical addr/data; continues to entry 3; o_error=0.
REQ-044 Entry 4 NACKs three times -> o_error=1, o_err_index=4, o_busy=0, gpio=1; a further i_start restarts from PWR_LOW with addr 0.
REQ-045 i_rst=0 asserted while o_iic_req=1 -> o_iic_req=0 and gpio=0 in the same cycle; spurious i_iic_done afterwards has no effect.
REQ-046 i_start pulsed during PWR_WAIT and WAIT_ACK -> ignored; timing and request count unchanged.

Source files
------------

// File: rtl/camera_init_seq.sv
// camera_init_seq: brings a camera out of reset and then writes a register
// table to it over IIC. The table is a synchronous ROM of
// {reg_addr[15:0], value[7:0]} entries. Two reg_addr values are special:
// 16'hFFFF ends the table and 16'hFFFE inserts a pause. A NACKed write is
// retried up to MAX_RETRY attempts in total before the sequence gives up.
module camera_init_seq #(
  parameter int RST_LOW_CYC  = 1000,
  parameter int PWR_WAIT_CYC = 20000,
  parameter int DELAY_UNIT   = 100,
  parameter int MAX_RETRY    = 3,
  parameter int TBL_AW       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [TBL_AW-1:0] o_tbl_addr,
  input  logic [23:0]       i_tbl_data,
  output logic              o_iic_req,
  output logic [15:0]       o_iic_addr,
  output logic [7:0]        o_iic_data,
  input  logic              i_iic_done,
  input  logic              i_iic_err,
  output logic              o_camera_gpio,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [TBL_AW-1:0] o_err_index
);

  // One shared down-counter serves both power phases and table delays. It
  // must hold the longest phase length minus one.
  localparam int PWR_MAX = (RST_LOW_CYC > PWR_WAIT_CYC) ? RST_LOW_CYC : PWR_WAIT_CYC;
  localparam int DLY_MAX = 255 * DELAY_UNIT;
  localparam int CNT_MAX = (PWR_MAX > DLY_MAX) ? PWR_MAX : DLY_MAX;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0]  PWR_LAST  = CNT_W'(PWR_WAIT_CYC - 1);
  localparam logic [TBL_AW-1:0] ADDR_LAST = {TBL_AW{1'b1}};
  localparam logic [15:0]       REG_END   = 16'hFFFF;
  localparam logic [15:0]       REG_DELAY = 16'hFFFE;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    PWR_LOW  = 4'd1,
    PWR_WAIT = 4'd2,
    FETCH    = 4'd3,
    DECODE   = 4'd4,
    WRITE    = 4'd5,
    WAIT_ACK = 4'd6,
    DELAY    = 4'd7,
    DONE     = 4'd8,
    ERROR    = 4'd9
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [RTY_W-1:0]  retry;
  logic [RTY_W-1:0]  retry_nxt;
  logic [31:0]       dly_prod;
  logic [CNT_W-1:0]  dly_load;
  logic [15:0]       tbl_reg;
  logic [7:0]        tbl_val;

  assign tbl_reg   = i_tbl_data[23:8];
  assign tbl_val   = i_tbl_data[7:0];
  assign retry_nxt = retry + RTY_W'(1);
  assign dly_prod  = {24'd0, tbl_val} * 32'(DELAY_UNIT);
  // A zero-length delay still spends one cycle in DELAY, so load 0 for it.
  assign dly_load  = (dly_prod == 32'd0) ? {CNT_W{1'b0}} : CNT_W'(dly_prod - 32'd1);

  // Sequencer FSM; every output is a register updated on state transitions.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= IDLE;
      cnt           <= {CNT_W{1'b0}};
      retry         <= {RTY_W{1'b0}};
      o_tbl_addr    <= {TBL_AW{1'b0}};
      o_iic_req     <= 1'b0;
      o_iic_addr    <= 16'h0000;
      o_iic_data    <= 8'h00;
      o_camera_gpio <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_err_index   <= {TBL_AW{1'b0}};
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (i_start) begin
            state         <= PWR_LOW;
            cnt           <= RST_LAST;
            retry         <= {RTY_W{1'b0}};
            o_tbl_addr    <= {TBL_AW{1'b0}};
            o_camera_gpio <= 1'b0;
            o_busy        <= 1'b1;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
          end
        end
        PWR_LOW: begin
          if (cnt == {CNT_W{1'b0}}) begin
            o_camera_gpio <= 1'b1;
            cnt           <= PWR_LAST;
            state         <= PWR_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PWR_WAIT: begin
          if (cnt == {CNT_W{1'b0}}) begin
            state <= FETCH;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        // The ROM registers o_tbl_addr during FETCH; its data is valid in DECODE.
        FETCH: begin
          state <= DECODE;
        end
        DECODE: begin
          if (tbl_reg == REG_END) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else if (tbl_reg == REG_DELAY) begin
            cnt   <= dly_load;
            state <= DELAY;
          end else begin
            o_iic_addr <= tbl_reg;
            o_iic_data <= tbl_val;
            state      <= WRITE;
          end
        end
        WRITE: begin
          o_iic_req <= 1'b1;
          state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (i_iic_done) begin
            o_iic_req <= 1'b0;
            if (!i_iic_err) begin
              retry <= {RTY_W{1'b0}};
              if (o_tbl_addr == ADDR_LAST) begin
                state  <= DONE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end else begin
                o_tbl_addr <= o_tbl_addr + TBL_AW'(1);
                state      <= FETCH;
              end
            end else if (retry_nxt < RTY_W'(MAX_RETRY)) begin
              retry <= retry_nxt;
              state <= WRITE;
            end else begin
              retry       <= retry_nxt;
              state       <= ERROR;
              o_busy      <= 1'b0;
              o_error     <= 1'b1;
              o_err_index <= o_tbl_addr;
            end
          end
        end
        DELAY: begin
          if (cnt == {CNT_W{1'b0}}) begin
            // The last table slot finishes the sequence instead of wrapping.
            if (o_tbl_addr == ADDR_LAST) begin
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              o_tbl_addr <= o_tbl_addr + TBL_AW'(1);
              state      <= FETCH;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          o_busy    <= 1'b0;
          o_iic_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
